block_state_controller: RTL and testbench

- Owns the 16x13 brick-field state for the breakout playfield and schedules all access to it.
- Supplies the brick painter with the 13-bit `block_line_state` of the row being drawn, prefetched on `new_frame`/`go_next_line`.
- Serves ball-collision hit requests (read-modify-write clear) and level-fill commands through a single row-wide storage port. Painter prefetch has fixed priority.

---
 rtl/breakout_pkg.sv | 27 ++
 rtl/block_state_ram.sv | 52 +++++
 rtl/block_state_controller.sv | 172 +++++++++++++++++
 tb/tb_block_state_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout brick-field state logic.
package breakout_pkg;

  localparam int BLOCKS_PER_ROW = 13;
  localparam int NUM_ROWS       = 16;
  localparam int ROW_IDX_W      = 4;

  typedef logic [BLOCKS_PER_ROW-1:0] row_word_t;
  typedef logic [ROW_IDX_W-1:0]      row_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIT_RD,
    ST_HIT_WR,
    ST_FILL
  } state_t;

  function automatic logic [3:0] row_popcount(input row_word_t w);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/block_state_ram.sv
// Single-port 16x13 brick array: one synchronous read or write per cycle.
// Reads land in one of two output registers so painter and hit reads never disturb each other.
module block_state_ram
  import breakout_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      we,
  input  logic      rd_disp,
  input  row_idx_t  addr,
  input  row_word_t wdata,
  output row_word_t disp_rdata,
  output row_word_t hold_rdata
);

  row_word_t mem_q [NUM_ROWS];
  row_word_t mem_d [NUM_ROWS];
  row_word_t disp_q, disp_d;
  row_word_t hold_q, hold_d;

  always_comb begin
    mem_d  = mem_q;
    disp_d = disp_q;
    hold_d = hold_q;
    if (en) begin
      if (we) begin
        mem_d[addr] = wdata;
      end else if (rd_disp) begin
        disp_d = mem_q[addr];
      end else begin
        hold_d = mem_q[addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      disp_q <= '0;
      hold_q <= '0;
    end else begin
      mem_q  <= mem_d;
      disp_q <= disp_d;
      hold_q <= hold_d;
    end
  end

  assign disp_rdata = disp_q;
  assign hold_rdata = hold_q;

endmodule

// File: rtl/block_state_controller.sv
// Brick-field owner: arbitrates the single row port between painter prefetch
// (fixed priority) and the hit read-modify-write / level-fill FSM.
module block_state_controller
  import breakout_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      Rst,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  input  logic                      hit_valid,
  output logic                      hit_ready,
  input  logic [3:0]                hit_row,
  input  logic [3:0]                hit_col,
  output logic                      resp_valid,
  output logic                      resp_hit,
  input  logic                      fill_start,
  input  logic [BLOCKS_PER_ROW-1:0] fill_pattern,
  output logic                      busy,
  output logic [CNT_W-1:0]          blocks_remaining,
  output logic                      all_cleared
);

  state_t     state_q, state_d;
  row_idx_t   disp_row_q, disp_row_d;
  logic       pend_q, pend_d;
  row_idx_t   hit_row_q, hit_row_d;
  logic [3:0] hit_col_q, hit_col_d;
  row_word_t  fill_pat_q, fill_pat_d;
  row_idx_t   fill_idx_q, fill_idx_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic      port_en, port_we, port_rd_disp;
  row_idx_t  port_addr;
  row_word_t port_wdata;
  row_word_t hold_word;
  row_word_t clr_mask;
  logic      col_in_range;
  logic      hit_bit;

  block_state_ram u_ram (
    .clk        (clk),
    .rst        (Rst),
    .en         (port_en),
    .we         (port_we),
    .rd_disp    (port_rd_disp),
    .addr       (port_addr),
    .wdata      (port_wdata),
    .disp_rdata (block_line_state),
    .hold_rdata (hold_word)
  );

  // Columns 13..15 shift the mask out entirely, so such a hit can never report a brick.
  assign clr_mask     = row_word_t'(1) << hit_col_q;
  assign col_in_range = hit_col_q < 4'(BLOCKS_PER_ROW);
  assign hit_bit      = |(hold_word & clr_mask);

  always_comb begin
    disp_row_d = disp_row_q;
    if (new_frame) begin
      disp_row_d = '0;
    end else if (go_next_line) begin
      disp_row_d = disp_row_q + row_idx_t'(1);
    end
    pend_d = new_frame | go_next_line;
  end

  always_comb begin
    state_d      = state_q;
    hit_row_d    = hit_row_q;
    hit_col_d    = hit_col_q;
    fill_pat_d   = fill_pat_q;
    fill_idx_d   = fill_idx_q;
    remaining_d  = remaining_q;
    port_en      = 1'b0;
    port_we      = 1'b0;
    port_rd_disp = 1'b0;
    port_addr    = hit_row_q;
    port_wdata   = '0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;

    if (pend_q) begin
      port_en      = 1'b1;
      port_rd_disp = 1'b1;
      port_addr    = disp_row_q;
    end

    // The FSM only touches the port when the painter is not prefetching.
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          fill_pat_d  = fill_pattern;
          fill_idx_d  = '0;
          remaining_d = '0;
          state_d     = ST_FILL;
        end else if (hit_valid) begin
          hit_row_d = row_idx_t'(hit_row);
          hit_col_d = hit_col;
          state_d   = ST_HIT_RD;
        end
      end
      ST_HIT_RD: begin
        if (!pend_q) begin
          port_en   = 1'b1;
          port_addr = hit_row_q;
          state_d   = ST_HIT_WR;
        end
      end
      ST_HIT_WR: begin
        if (!pend_q) begin
          resp_valid = 1'b1;
          resp_hit   = col_in_range & hit_bit;
          if (col_in_range) begin
            port_en    = 1'b1;
            port_we    = 1'b1;
            port_addr  = hit_row_q;
            port_wdata = hold_word & ~clr_mask;
          end
          if (resp_hit && (remaining_q != '0)) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (!pend_q) begin
          port_en     = 1'b1;
          port_we     = 1'b1;
          port_addr   = fill_idx_q;
          port_wdata  = fill_pat_q;
          remaining_d = remaining_q + CNT_W'(row_popcount(fill_pat_q));
          fill_idx_d  = fill_idx_q + row_idx_t'(1);
          if (fill_idx_q == row_idx_t'(NUM_ROWS - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      disp_row_q  <= '0;
      pend_q      <= 1'b0;
      hit_row_q   <= '0;
      hit_col_q   <= '0;
      fill_pat_q  <= '0;
      fill_idx_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      disp_row_q  <= disp_row_d;
      pend_q      <= pend_d;
      hit_row_q   <= hit_row_d;
      hit_col_q   <= hit_col_d;
      fill_pat_q  <= fill_pat_d;
      fill_idx_q  <= fill_idx_d;
      remaining_q <= remaining_d;
    end
  end

  assign hit_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign blocks_remaining = remaining_q;
  assign all_cleared      = (remaining_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_block_state_controller.sv
// Bench for block_state_controller: directed scenarios plus random traffic,
// checked every cycle against a port-grant level model of the brick field.
module tb_block_state_controller;

  logic        clk;
  logic        rst;
  logic        new_frame;
  logic        go_next_line;
  logic [12:0] block_line_state;
  logic        hit_valid;
  logic        hit_ready;
  logic [3:0]  hit_row;
  logic [3:0]  hit_col;
  logic        resp_valid;
  logic        resp_hit;
  logic        fill_start;
  logic [12:0] fill_pattern;
  logic        busy;
  logic [7:0]  blocks_remaining;
  logic        all_cleared;

  int checks = 0;
  int passes = 0;

  block_state_controller dut (
    .clk              (clk),
    .Rst              (rst),
    .new_frame        (new_frame),
    .go_next_line     (go_next_line),
    .block_line_state (block_line_state),
    .hit_valid        (hit_valid),
    .hit_ready        (hit_ready),
    .hit_row          (hit_row),
    .hit_col          (hit_col),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .fill_start       (fill_start),
    .fill_pattern     (fill_pattern),
    .busy             (busy),
    .blocks_remaining (blocks_remaining),
    .all_cleared      (all_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: field contents, display snapshot, and the operation in flight counted in port grants.
  logic [12:0] m_mem [16];
  logic [12:0] m_bls;
  logic [12:0] m_pat;
  int  m_disp, m_rem, m_op, m_grants, m_row, m_col, m_idx;
  bit  m_pend;
  bit  m_ok = 0;

  function automatic bit exp_rv();
    return (m_op == 1) && (m_grants == 1) && !m_pend;
  endfunction

  function automatic bit exp_rh();
    if (!exp_rv() || m_col >= 13) return 0;
    return m_mem[m_row][m_col];
  endfunction

  task automatic model_step();
    bit free;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_bls = '0; m_disp = 0; m_pend = 0; m_rem = 0; m_op = 0; m_grants = 0;
      m_ok = 1;
    end else if (m_ok) begin
      free = !m_pend;
      if (m_pend) m_bls = m_mem[m_disp];
      case (m_op)
        0: begin
          if (fill_start) begin
            m_op = 2; m_idx = 0; m_rem = 0; m_pat = fill_pattern;
          end else if (hit_valid) begin
            m_op = 1; m_grants = 0; m_row = int'(hit_row); m_col = int'(hit_col);
          end
        end
        1: if (free) begin
          if (m_grants == 0) m_grants = 1;
          else begin
            if (m_col < 13 && m_mem[m_row][m_col]) begin
              m_mem[m_row][m_col] = 1'b0;
              if (m_rem > 0) m_rem--;
            end
            m_op = 0;
          end
        end
        default: if (free) begin
          m_mem[m_idx] = m_pat;
          m_rem += $countones(m_pat);
          m_idx++;
          if (m_idx == 16) m_op = 0;
        end
      endcase
      m_pend = new_frame || go_next_line;
      if (new_frame) m_disp = 0;
      else if (go_next_line) m_disp = (m_disp + 1) % 16;
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("hit_ready", 32'(hit_ready), 32'(m_op == 0));
      chk("busy", 32'(busy), 32'(m_op != 0));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv()));
      if (exp_rv()) chk("resp_hit", 32'(resp_hit), 32'(exp_rh()));
      chk("blocks_remaining", 32'(blocks_remaining), 32'(m_rem));
      chk("all_cleared", 32'(all_cleared), 32'(m_rem == 0 && m_op == 0));
      chk("block_line_state", 32'(block_line_state), 32'(m_bls));
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line(input bit frame);
    if (frame) new_frame = 1'b1; else go_next_line = 1'b1;
    tick();
    new_frame = 1'b0;
    go_next_line = 1'b0;
  endtask

  task automatic do_fill(input logic [12:0] pat, output int cycles);
    fill_start = 1'b1;
    fill_pattern = pat;
    tick();
    fill_start = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin tick(); cycles++; end
  endtask

  task automatic do_hit(input int row, input int col, input bit nl_in_rd,
                        output bit got, output int lat);
    int n;
    n = 0;
    while (!hit_ready && n < 50) begin tick(); n++; end
    hit_valid = 1'b1;
    hit_row = 4'(row);
    hit_col = 4'(col);
    tick();
    hit_valid = 1'b0;
    lat = 0;
    if (nl_in_rd) begin
      go_next_line = 1'b1;
      tick();
      go_next_line = 1'b0;
      lat = 1;
    end
    while (!resp_valid && lat < 10) begin tick(); lat++; end
    got = resp_hit;
    tick();
  endtask

  initial begin
    bit got;
    int lat, n, pulses;
    rst = 1'b1; new_frame = 0; go_next_line = 0; hit_valid = 0;
    hit_row = '0; hit_col = '0; fill_start = 0; fill_pattern = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_hit_ready", 32'(hit_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_all_cleared", 32'(all_cleared), 32'd1);
    chk("reset_remaining", 32'(blocks_remaining), 32'd0);
    chk("reset_bls", 32'(block_line_state), 32'd0);

    do_fill(13'h1FFF, n);
    chk("fill_busy_cycles", 32'(n), 32'd16);
    chk("fill_remaining", 32'(blocks_remaining), 32'd208);
    chk("fill_all_cleared", 32'(all_cleared), 32'd0);
    pulse_line(1);
    chk("prefetch_not_yet", 32'(block_line_state), 32'h0);
    tick();
    chk("prefetch_row0", 32'(block_line_state), 32'h1FFF);

    do_hit(3, 5, 0, got, lat);
    chk("hit_latency", 32'(lat), 32'd1);
    chk("hit_present", 32'(got), 32'd1);
    chk("hit_remaining", 32'(blocks_remaining), 32'd207);
    do_hit(3, 5, 0, got, lat);
    chk("rehit_absent", 32'(got), 32'd0);
    chk("rehit_remaining", 32'(blocks_remaining), 32'd207);

    do_hit(3, 6, 1, got, lat);
    chk("contend_latency", 32'(lat), 32'd2);
    chk("contend_hit", 32'(got), 32'd1);
    chk("contend_row1", 32'(block_line_state), 32'h1FFF);
    chk("contend_remaining", 32'(blocks_remaining), 32'd206);

    do_fill(13'h0001, n);
    pulse_line(1);
    tick();
    chk("wrap_row0", 32'(block_line_state), 32'h0001);
    for (int k = 1; k < 16; k++) begin
      pulse_line(0);
      tick();
      chk("wrap_rowk", 32'(block_line_state), 32'h0001);
    end
    do_hit(0, 0, 0, got, lat);
    chk("clear_row0", 32'(got), 32'd1);
    pulse_line(0);
    tick();
    chk("wrap_back_to_row0", 32'(block_line_state), 32'h0000);

    do_hit(2, 13, 0, got, lat);
    chk("col13_latency", 32'(lat), 32'd1);
    chk("col13_no_hit", 32'(got), 32'd0);
    chk("col13_remaining", 32'(blocks_remaining), 32'd15);

    fill_start = 1'b1; fill_pattern = 13'h0001;
    hit_valid = 1'b1; hit_row = 4'd5; hit_col = 4'd0;
    tick();
    fill_start = 1'b0; hit_valid = 1'b0;
    chk("fill_prio_busy", 32'(busy), 32'd1);
    chk("fill_prio_ready", 32'(hit_ready), 32'd0);
    n = 0; pulses = 0;
    while (busy && n < 40) begin
      if (resp_valid) pulses++;
      tick(); n++;
    end
    chk("fill_prio_no_resp", 32'(pulses), 32'd0);
    chk("fill_prio_remaining", 32'(blocks_remaining), 32'd16);

    for (int r = 0; r < 16; r++) begin
      do_hit(r, 0, 0, got, lat);
      chk("clear_all_hit", 32'(got), 32'd1);
    end
    chk("clear_all_remaining", 32'(blocks_remaining), 32'd0);
    chk("clear_all_cleared", 32'(all_cleared), 32'd1);

    fill_start = 1'b1; fill_pattern = 13'h1FFF;
    tick();
    fill_start = 1'b0;
    repeat (7) tick();
    chk("midfill_remaining", 32'(blocks_remaining), 32'd91);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(hit_ready), 32'd1);
    chk("abort_remaining", 32'(blocks_remaining), 32'd0);
    chk("abort_all_cleared", 32'(all_cleared), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    pulse_line(1);
    tick();
    chk("abort_array_cleared", 32'(block_line_state), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(499) == 0);
      new_frame    = ($urandom_range(39) == 0);
      go_next_line = ($urandom_range(7) == 0);
      hit_valid    = ($urandom_range(2) == 0);
      hit_row      = 4'($urandom_range(15));
      hit_col      = 4'($urandom_range(15));
      fill_start   = ($urandom_range(199) == 0);
      fill_pattern = 13'($urandom);
      tick();
    end
    rst = 0; new_frame = 0; go_next_line = 0; hit_valid = 0; fill_start = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
